bcd2bin_seq: RTL and testbench
==============================

// Module: bcd2bin_seq
// PURPOSE
//  Sequential BCD-to-binary converter using reverse double-dabble: shift right, then subtract 3 from any digit >= 8.
//  It is the inverse of the score binary-to-BCD path.
//  Converts a DIGITS-wide packed BCD value (e.g. a score or settings value entered digit by digit) into binary.
//  Conversion takes one bit per clock under a start/busy/done handshake, so the game logic can consume the result.
// PARAMETERS
//  DIGITS  2  number of packed BCD digits on bcd_in (digit 0 = bits [3:0], the LSD)
//  BIN_W   7  binary result width; must satisfy 2**BIN_W >= 10**DIGITS (2->7, 3->10, 4->14)
// PORTS
//  clk      in   1         system clock, all logic on rising edge
//  rst_n    in   1         synchronous reset, active low
//  start    in   1         request conversion; sampled only when busy==0
//  bcd_in   in   4*DIGITS  packed BCD operand, captured on the accepting edge
//  busy     out  1         high from the accepting edge until done drops
//  done     out  1         one-cycle pulse: bin_out/err valid and updated
//  bin_out  out  BIN_W     binary result, held until the next done
//  err      out  1         set with done if any input digit > 9, held until next done
// BEHAVIOUR
//  - Clock and reset: one clock, clk; reset rst_n is synchronous and active-low.
//  - Reset values: state=IDLE, busy=0, done=0, bin_out=0, err=0, internal shift/count registers 0.
//  - Reset mid-conversion aborts the conversion: no done pulse; outputs return to reset values.
//  - FSM states: IDLE, CONV, DONE.
//    IDLE: if start=1 at an edge, load bcd_sr<=bcd_in, bin_sr<=0, cnt<=0, and go to CONV.
//      At the same edge, latch err_q = OR over digits of (digit > 4'd9).
//    CONV: each edge performs one step: {bcd_sr,bin_sr} <= {bcd_sr,bin_sr} >> 1.
//      Then, combinationally within the same step, each shifted digit >= 8 gets -3 (4-bit wrap-free).
//      cnt increments each step.
//      On the edge performing step BIN_W (cnt==BIN_W-1): go to DONE, done<=1, err<=err_q.
//      On that edge, bin_out <= err_q ? 0 : final bin_sr.
//    DONE: one cycle only; next edge done<=0 and go to IDLE. start is ignored in DONE.
//  - busy = (state != IDLE), combinational from state.
//  - Latency: the start edge is E0; done is high in the cycle after edge E0+BIN_W.
//    For BIN_W=7, done is visible after the 7th edge following the start edge.
//    The earliest next acceptance is the edge after done falls.
//  - Throughput: one conversion per BIN_W+2 cycles.
//  - start while busy=1 is dropped, with no queueing.
//  - bcd_in changes after acceptance do not affect the result.
//  - Correctness: for valid input, bin_out equals the decimal value exactly.
//    bcd_sr is all zero after BIN_W steps; implementation may assert this in simulation.
//  - Invalid digits (A-F) still run full latency (deterministic timing); result forced to 0, err=1.
//  - bin_out and err change only on the done edge or on reset.
// TESTING
//  1. DIGITS=2: bcd_in=8'h42, start 1 cycle -> busy 1; done pulses 7 edges later, bin_out=7'd42, err=0.
//  2. Boundaries: 8'h00 -> bin_out=0; 8'h99 -> bin_out=7'd99; 8'h09 -> 9; 8'h10 -> 10; all err=0.
//  3. Invalid: 8'h1A -> done after same latency, bin_out=0, err=1.
//     A following 8'h05 -> bin_out=5, err=0.
//  4. start held high continuously with 8'h37, bcd_in changed to 8'h55 mid-conversion.
//     -> first result 37; start is ignored while busy.
//     -> the next conversion is accepted the cycle after done falls and returns 55.
//  5. rst_n low for 1 cycle at step 3 of a conversion -> no done.
//     -> outputs return to reset values; a new start of 8'h21 yields 21.
//  6. DIGITS=3, BIN_W=10: exhaustive 000..999 -> bin_out matches, done 10 edges after start each time.

Source files
------------

// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: reverse double-dabble BCD-to-binary, one bit per clk; ports clk, rst_n, start, bcd_in -> busy, done, bin_out, err
module bcd2bin_seq #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] bcd_q, bcd_d, sh_bcd, adj;
  logic [BIN_W-1:0] bin_q, bin_d, sh_bin, bin_out_q, bin_out_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DIGITS-1:0] dig_bad;
  logic err_q, err_d, err_out_q, err_out_d, last;
  assign {sh_bcd, sh_bin} = {bcd_q, bin_q} >> 1;
  genvar d;
  for (d = 0; d < DIGITS; d++) begin : g_dig
    assign adj[4*d+:4] = sh_bcd[4*d+:4] >= 4'd8 ? sh_bcd[4*d+:4] - 4'd3 : sh_bcd[4*d+:4];
    assign dig_bad[d] = bcd_in[4*d+:4] > 4'd9;
  end
  assign last = cnt_q == CW'(BIN_W - 1);
  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    bin_out_d = bin_out_q;
    err_out_d = err_out_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = CONV;
        bcd_d   = bcd_in;
        bin_d   = '0;
        cnt_d   = '0;
        err_d   = |dig_bad;
      end
      CONV: begin
        bcd_d = adj;
        bin_d = sh_bin;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d   = DONE;
          bin_out_d = err_q ? '0 : sh_bin;
          err_out_d = err_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      bin_out_q <= '0;
      err_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      bin_out_q <= bin_out_d;
      err_out_q <= err_out_d;
    end
  end
  assign busy    = state_q != IDLE;
  assign done    = state_q == DONE;
  assign bin_out = bin_out_q;
  assign err     = err_out_q;
endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb_bcd2bin_seq: directed vector table plus handshake/reset corner sequences and an exhaustive 3-digit sweep
module tb_bcd2bin_seq;
  logic clk = 0, rst_n = 0, start = 0, start3 = 0;
  logic busy, done, err, busy3, done3, err3;
  logic [7:0] bcd_in = '0;
  logic [11:0] bcd3 = '0;
  logic [6:0] bin_out;
  logic [9:0] bin3;
  int checks = 0, failures = 0;
  typedef struct { logic [7:0] bcd; int bin; logic e; } vec_t;
  vec_t vt[7];
  always #5 clk = ~clk;
  bcd2bin_seq u2 (.clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
                  .busy(busy), .done(done), .bin_out(bin_out), .err(err));
  bcd2bin_seq #(.DIGITS(3), .BIN_W(10)) u3 (.clk(clk), .rst_n(rst_n), .start(start3), .bcd_in(bcd3),
                  .busy(busy3), .done(done3), .bin_out(bin3), .err(err3));
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask
  task automatic run(input logic [7:0] v, input int exp_b, input logic exp_e, input string nm);
    int n;
    @(negedge clk); start = 1; bcd_in = v;
    @(posedge clk); #1 start = 0;
    chk({nm, " busy"}, int'(busy), 1);
    wait_done(n);
    chk({nm, " latency"}, n, 7);
    chk({nm, " bin"}, int'(bin_out), exp_b);
    chk({nm, " err"}, int'(err), int'(exp_e));
    @(posedge clk); #1;
    chk({nm, " done_fall"}, int'(done), 0);
    chk({nm, " idle"}, int'(busy), 0);
    chk({nm, " bin_held"}, int'(bin_out), exp_b);
  endtask
  initial begin
    int n, m;
    logic [11:0] b;
    vt = '{'{8'h42, 42, 1'b0}, '{8'h00, 0, 1'b0}, '{8'h99, 99, 1'b0}, '{8'h09, 9, 1'b0},
           '{8'h10, 10, 1'b0}, '{8'h1A, 0, 1'b1}, '{8'h05, 5, 1'b0}};
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst bin", int'(bin_out), 0);
    chk("rst err", int'(err), 0);
    chk("rst busy3", int'(busy3), 0);
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 7; i++) run(vt[i].bcd, vt[i].bin, vt[i].e, $sformatf("vec%0d", i));
    @(negedge clk); start = 1; bcd_in = 8'h37;
    @(posedge clk); #1;
    chk("hold busy", int'(busy), 1);
    n = 0;
    repeat (3) begin @(posedge clk); #1; n++; end
    bcd_in = 8'h55;
    wait_done(m);
    chk("hold latency1", n + m, 7);
    chk("hold bin1", int'(bin_out), 37);
    @(posedge clk); #1;
    chk("hold done_fall", int'(done), 0);
    chk("hold idle", int'(busy), 0);
    @(posedge clk); #1;
    chk("hold accept2", int'(busy), 1);
    start = 0;
    wait_done(m);
    chk("hold latency2", m, 7);
    chk("hold bin2", int'(bin_out), 55);
    @(posedge clk); #1;
    run(8'h9F, 0, 1'b1, "bad_hi");
    @(negedge clk); start = 1; bcd_in = 8'h37;
    @(posedge clk); #1 start = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 0;
    @(posedge clk); #1;
    chk("abort busy", int'(busy), 0);
    chk("abort done", int'(done), 0);
    chk("abort bin", int'(bin_out), 0);
    chk("abort err", int'(err), 0);
    @(negedge clk) rst_n = 1;
    n = 0;
    repeat (12) begin @(posedge clk); #1; if (done) n++; end
    chk("abort no_done", n, 0);
    run(8'h21, 21, 1'b0, "post_rst");
    for (int i = 0; i < 1000; i++) begin
      b = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
      @(negedge clk); start3 = 1; bcd3 = b;
      @(posedge clk); #1 start3 = 0;
      n = 0;
      while (done3 !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
      chk($sformatf("d3 lat %0d", i), n, 10);
      chk($sformatf("d3 bin %0d", i), int'(bin3), i);
      chk($sformatf("d3 err %0d", i), int'(err3), 0);
      @(posedge clk); #1;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
